// File: rtl/scan_pkg.sv
// Shared types and default parameters for the seven-segment scan driver.
package scan_pkg;

    typedef logic [3:0] nibble_t;

    localparam int SCAN_DIGITS_DEF = 8;
    localparam int SCAN_DIV_DEF    = 1000;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } scan_state_e;

endpackage

// File: rtl/scan_prescaler.sv
// Divides the clock into a one-cycle tick every SCAN_DIV clocks.
module scan_prescaler #(
    parameter int SCAN_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] PCNT_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] pcnt_q;
    logic [CW-1:0] pcnt_d;

    // Terminal count detection and wrap of the prescaler.
    always_comb begin
        tick = (pcnt_q == PCNT_LAST);
        if (tick) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + CW'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/hex_scan_driver.sv
// Time-multiplexed hex scan driver; loads are staged and committed only at
// frame boundaries so a frame never mixes old and new digits.
module hex_scan_driver
    import scan_pkg::*;
#(
    parameter int DIGITS   = SCAN_DIGITS_DEF,
    parameter int SCAN_DIV = SCAN_DIV_DEF,
    parameter int LZ_BLANK = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_valid,
    input  logic [4*DIGITS-1:0] load_data,
    output logic                load_ready,
    output logic [DIGITS-1:0]   digit_sel,
    output logic [3:0]          bcd,
    output logic                en
);

    localparam int IW = $clog2(DIGITS);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic                tick;
    logic                wrap;
    logic [IW-1:0]       idx_q;
    logic [IW-1:0]       idx_d;
    logic [4*DIGITS-1:0] disp_q;
    logic [4*DIGITS-1:0] disp_d;
    logic [4*DIGITS-1:0] pend_q;
    logic [4*DIGITS-1:0] pend_d;
    scan_state_e         state_q;
    scan_state_e         state_d;
    logic                upper_nz;
    nibble_t             cur_nib;

    scan_prescaler #(
        .SCAN_DIV (SCAN_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Digit index advance and frame-boundary detection.
    always_comb begin
        wrap = tick && (idx_q == IDX_LAST);
        if (!tick) begin
            idx_d = idx_q;
        end else if (idx_q == IDX_LAST) begin
            idx_d = '0;
        end else begin
            idx_d = idx_q + IW'(1);
        end
    end

    // Load handshake FSM; a load accepted on the wrap cycle waits for the next wrap.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        disp_d     = disp_q;
        load_ready = (state_q == ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (load_valid) begin
                    pend_d  = load_data;
                    state_d = ST_PENDING;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (wrap) begin
                    disp_d  = pend_q;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PENDING;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, index and value registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            disp_q  <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            pend_q  <= pend_d;
        end
    end

    // Digit decode purely from registers: select, nibble and leading-zero enable.
    always_comb begin
        cur_nib   = 4'h0;
        upper_nz  = 1'b0;
        digit_sel = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                digit_sel[i] = 1'b0;
                cur_nib      = disp_q[4*i +: 4];
            end else begin
                digit_sel[i] = 1'b1;
            end
            if ((i >= int'(idx_q)) && (disp_q[4*i +: 4] != 4'h0)) begin
                upper_nz = 1'b1;
            end else begin
                upper_nz = upper_nz;
            end
        end
        bcd = cur_nib;
        if ((idx_q == '0) || (LZ_BLANK == 0)) begin
            en = 1'b1;
        end else begin
            en = upper_nz;
        end
    end

endmodule

// File: tb/tb_hex_scan_driver.sv
// Self-checking bench: a cycle-count based model of the scan driver is compared
// against the DUT every cycle, plus hand-computed expectations for key moments.
module tb_hex_scan_driver;

    localparam int ND  = 8;
    localparam int DIV = 4;
    localparam int FRAME = ND * DIV;

    logic        clk;
    logic        rst;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_ready;
    logic [7:0]  digit_sel;
    logic [3:0]  bcd;
    logic        en;
    logic        load_ready_nb;
    logic [7:0]  digit_sel_nb;
    logic [3:0]  bcd_nb;
    logic        en_nb;

    int n_checks = 0;
    int n_fail   = 0;

    // model state: cycles since reset, displayed/pending values
    int          m_t;
    logic [31:0] m_disp;
    logic [31:0] m_pend;
    logic        m_pending;

    hex_scan_driver #(.DIGITS(ND), .SCAN_DIV(DIV), .LZ_BLANK(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .digit_sel  (digit_sel),
        .bcd        (bcd),
        .en         (en)
    );

    hex_scan_driver #(.DIGITS(ND), .SCAN_DIV(DIV), .LZ_BLANK(0)) dut_nb (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready_nb),
        .digit_sel  (digit_sel_nb),
        .bcd        (bcd_nb),
        .en         (en_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame position from cycle count, commit at every frame end.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t       = 0;
            m_disp    = 32'h0;
            m_pend    = 32'h0;
            m_pending = 1'b0;
        end else begin
            if (m_pending && ((m_t % FRAME) == FRAME - 1)) begin
                m_disp    = m_pend;
                m_pending = 1'b0;
            end else if (!m_pending && load_valid) begin
                m_pend    = load_data;
                m_pending = 1'b1;
            end
            m_t = m_t + 1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        int          i;
        logic [31:0] upper;
        i     = (m_t / DIV) % ND;
        upper = m_disp >> (4 * i);
        check("digit_sel", {24'h0, digit_sel}, {24'h0, ~(8'h01 << i)});
        check("bcd", {28'h0, bcd}, {28'h0, upper[3:0]});
        check("en", {31'h0, en}, {31'h0, (i == 0) || (upper != 32'h0)});
        check("load_ready", {31'h0, load_ready}, {31'h0, !m_pending});
        check("en_noblank", {31'h0, en_nb}, 32'h1);
        check("bcd_noblank", {28'h0, bcd_nb}, {28'h0, upper[3:0]});
    end

    task automatic wait_ready();
        int k;
        k = 0;
        while (!load_ready && k < 3 * FRAME) begin
            @(negedge clk);
            k++;
        end
        if (!load_ready) check("ready_timeout", 32'h0, 32'h1);
    endtask

    task automatic do_load(input logic [31:0] d);
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = d;
        wait_ready();
        @(negedge clk);
        load_valid = 1'b0;
        load_data  = $urandom;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_sel", {24'h0, digit_sel}, 32'hFE);
        check("rst_bcd", {28'h0, bcd}, 32'h0);
        check("rst_en", {31'h0, en}, 32'h1);
        check("rst_ready", {31'h0, load_ready}, 32'h1);
        repeat (4) @(posedge clk);
        #1 check("sel_after4", {24'h0, digit_sel}, 32'hFD);
        repeat (28) @(posedge clk);
        #1 check("sel_after32", {24'h0, digit_sel}, 32'hFE);

        // mid-frame load, then back-pressured second load
        repeat (4) @(posedge clk);
        do_load(32'h1234ABCD);
        check("pending_ready", {31'h0, load_ready}, 32'h0);
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 32'h0000FFFF;
        wait_ready();
        check("commit_bcd0", {28'h0, bcd}, 32'hD);
        check("commit_sel0", {24'h0, digit_sel}, 32'hFE);
        repeat (4 * DIV) @(negedge clk);
        check("commit_bcd4", {28'h0, bcd}, 32'h4);
        load_valid = 1'b0;
        check("bp_accepted", {31'h0, load_ready}, 32'h0);
        wait_ready();
        check("ffff_bcd0", {28'h0, bcd}, 32'hF);
        repeat (4 * DIV) @(negedge clk);
        check("ffff_bcd4", {28'h0, bcd}, 32'h0);
        check("ffff_en4", {31'h0, en}, 32'h0);

        // leading-zero blanking
        do_load(32'h00000050);
        wait_ready();
        check("lz_d0_bcd", {28'h0, bcd}, 32'h0);
        check("lz_d0_en", {31'h0, en}, 32'h1);
        repeat (DIV) @(negedge clk);
        check("lz_d1_bcd", {28'h0, bcd}, 32'h5);
        check("lz_d1_en", {31'h0, en}, 32'h1);
        repeat (DIV) @(negedge clk);
        check("lz_d2_en", {31'h0, en}, 32'h0);
        check("nb_d2_en", {31'h0, en_nb}, 32'h1);
        do_load(32'h00000000);
        wait_ready();
        check("zero_d0_en", {31'h0, en}, 32'h1);
        repeat (DIV) @(negedge clk);
        check("zero_d1_en", {31'h0, en}, 32'h0);

        // load accepted exactly on the wrap edge
        for (int k = 0; k < 2 * FRAME && (m_t % FRAME) != FRAME - 1; k++) @(negedge clk);
        load_valid = 1'b1;
        load_data  = 32'h87654321;
        @(negedge clk);
        load_valid = 1'b0;
        check("wrapload_ready", {31'h0, load_ready}, 32'h0);
        check("wrapload_old", {28'h0, bcd}, 32'h0);
        repeat (FRAME - 1) @(negedge clk);
        check("wrapload_still", {31'h0, load_ready}, 32'h0);
        @(negedge clk);
        check("wrapload_new", {28'h0, bcd}, 32'h1);
        check("wrapload_rdy", {31'h0, load_ready}, 32'h1);

        // randomized traffic
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            load_valid = ($urandom_range(0, 7) == 0);
            load_data  = $urandom;
        end
        @(negedge clk);
        load_valid = 1'b0;

        // asynchronous reset while pending
        wait_ready();
        do_load(32'hDEADBEEF);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_sel", {24'h0, digit_sel}, 32'hFE);
        check("arst_bcd", {28'h0, bcd}, 32'h0);
        check("arst_en", {31'h0, en}, 32'h1);
        check("arst_ready", {31'h0, load_ready}, 32'h1);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_bcd", {28'h0, bcd}, 32'h0);
        repeat (2 * FRAME) @(negedge clk);
        check("post_rst_ready", {31'h0, load_ready}, 32'h1);
        check("post_rst_bcd2", {28'h0, bcd}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
